// File: rtl/mem2axi_deframer.sv
// Rebuilds 256-bit AXI4-Stream beats from 202-bit memory words: one header word carrying tuser,
// then 192-bit payload words tagged 1,2,3,4,1,... whose payload is packed LSB-first into beats.
module mem2axi_deframer #(
  parameter int DATA_W = 256,
  parameter int USER_W = 128,
  parameter int WORD_W = 202
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORD_W-1:0]     din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [DATA_W-1:0]     m_axis_tdata,
  output logic [DATA_W/8-1:0]   m_axis_tstrb,
  output logic [USER_W-1:0]     m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  seq_err,
  output logic [31:0]           pkt_count
);

  localparam int PAY_W  = WORD_W - 10;
  localparam int ACC_W  = 2 * PAY_W;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {S_HDR, S_DATA, S_FLUSH, S_DROP} state_t;

  state_t              state_reg;
  logic [ACC_W-1:0]    acc_reg;
  logic [2:0]          exp_type_reg;
  logic                flush_pend_reg;
  logic [STRB_W-1:0]   flush_strb_reg;
  logic [USER_W-1:0]   tuser_reg;

  logic [PAY_W-1:0]    w_pay;
  logic [4:0]          w_last_idx;
  logic [2:0]          w_type;
  logic                w_last;
  logic                unused_bits;
  logic                out_free;
  logic                accept;
  logic [ACC_W-1:0]    combined;
  logic [STRB_W-1:0]   strb_last;

  assign w_pay       = din[WORD_W-1:10];
  assign w_last_idx  = din[9:5];
  assign w_type      = din[4:2];
  assign w_last      = din[1];
  assign unused_bits = din[0];

  assign out_free  = !m_axis_tvalid || m_axis_tready;
  assign din_ready = !reset && (state_reg != S_FLUSH) && out_free;
  assign accept    = din_valid && din_ready;

  // The word type fixes how many residue bits sit below the new payload.
  always_comb begin
    combined = '0;
    unique case (w_type)
      3'd1:    combined = ACC_W'(w_pay);
      3'd2:    combined = {w_pay, acc_reg[PAY_W-1:0]};
      3'd3:    combined = ACC_W'({w_pay, acc_reg[127:0]});
      default: combined = ACC_W'({w_pay, acc_reg[63:0]});
    endcase
  end

  for (genvar gi = 0; gi < STRB_W; gi++) begin : g_strb
    assign strb_last[gi] = (5'(gi) <= w_last_idx);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_HDR;
      acc_reg        <= '0;
      exp_type_reg   <= 3'd1;
      flush_pend_reg <= 1'b0;
      flush_strb_reg <= '0;
      tuser_reg      <= '0;
      m_axis_tdata   <= '0;
      m_axis_tstrb   <= '0;
      m_axis_tuser   <= '0;
      m_axis_tlast   <= 1'b0;
      m_axis_tvalid  <= 1'b0;
      seq_err        <= 1'b0;
      pkt_count      <= '0;
    end else begin
      seq_err <= 1'b0;
      if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;

      unique case (state_reg)
        S_HDR: begin
          if (accept) begin
            if (w_type == 3'd0) begin
              tuser_reg    <= din[10 +: USER_W];
              exp_type_reg <= 3'd1;
              acc_reg      <= '0;
              if (!w_last) state_reg <= S_DATA;
            end else begin
              seq_err <= 1'b1;
              if (!w_last) state_reg <= S_DROP;
            end
          end
        end

        S_DATA: begin
          if (accept) begin
            if (w_type == exp_type_reg) begin
              if (w_last && w_type == 3'd2) begin
                // 384 bits pending: full beat now, the zero-padded rest from FLUSH.
                m_axis_tdata   <= combined[DATA_W-1:0];
                m_axis_tstrb   <= '1;
                m_axis_tlast   <= 1'b0;
                m_axis_tuser   <= tuser_reg;
                m_axis_tvalid  <= 1'b1;
                acc_reg        <= ACC_W'(combined[ACC_W-1:DATA_W]);
                flush_strb_reg <= strb_last;
                flush_pend_reg <= 1'b1;
                state_reg      <= S_FLUSH;
              end else if (w_last) begin
                m_axis_tdata  <= combined[DATA_W-1:0];
                m_axis_tstrb  <= strb_last;
                m_axis_tlast  <= 1'b1;
                m_axis_tuser  <= tuser_reg;
                m_axis_tvalid <= 1'b1;
                acc_reg       <= '0;
                pkt_count     <= pkt_count + 32'd1;
                state_reg     <= S_HDR;
              end else begin
                if (w_type == 3'd1) begin
                  acc_reg <= combined;
                end else begin
                  m_axis_tdata  <= combined[DATA_W-1:0];
                  m_axis_tstrb  <= '1;
                  m_axis_tlast  <= 1'b0;
                  m_axis_tuser  <= tuser_reg;
                  m_axis_tvalid <= 1'b1;
                  acc_reg       <= ACC_W'(combined[ACC_W-1:DATA_W]);
                end
                exp_type_reg <= (w_type == 3'd4) ? 3'd1 : w_type + 3'd1;
              end
            end else begin
              seq_err   <= 1'b1;
              acc_reg   <= '0;
              state_reg <= w_last ? S_HDR : S_DROP;
            end
          end
        end

        S_FLUSH: begin
          if (flush_pend_reg && out_free) begin
            m_axis_tdata   <= acc_reg[DATA_W-1:0];
            m_axis_tstrb   <= flush_strb_reg;
            m_axis_tlast   <= 1'b1;
            m_axis_tuser   <= tuser_reg;
            m_axis_tvalid  <= 1'b1;
            acc_reg        <= '0;
            flush_pend_reg <= 1'b0;
            pkt_count      <= pkt_count + 32'd1;
          end else if (!flush_pend_reg && m_axis_tvalid && m_axis_tready) begin
            state_reg <= S_HDR;
          end
        end

        S_DROP: begin
          if (accept && w_last) state_reg <= S_HDR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem2axi_deframer.sv
// Directed bench for mem2axi_deframer: expected beats come from a 32-bit lane stream model
// of the payload words sent, compared field by field at the beat handshake.
module tb_mem2axi_deframer;

  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  strb;
    logic [127:0] user;
    logic         last;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [201:0] din = '0;
  logic         din_valid = 1'b0;
  logic         din_ready;
  logic [255:0] m_axis_tdata;
  logic [31:0]  m_axis_tstrb;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tlast;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         seq_err;
  logic [31:0]  pkt_count;

  logic tready_lvl = 1'b1;
  logic toggle_en  = 1'b0;
  logic tog        = 1'b0;
  assign m_axis_tready = toggle_en ? tog : tready_lvl;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int seq_err_cnt = 0;
  int exp_pkts = 0;

  beat_t got_q[$];
  beat_t exp_q[$];
  beat_t snap;
  logic  stall_prev = 1'b0;

  localparam logic [127:0] TU_AF = {96'b0, 8'hAF, 24'h000001};
  localparam logic [127:0] TU_EA = {96'b0, 8'hEA, 24'h000002};

  mem2axi_deframer dut (
    .clk           (clk),
    .reset         (reset),
    .din           (din),
    .din_valid     (din_valid),
    .din_ready     (din_ready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .seq_err       (seq_err),
    .pkt_count     (pkt_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (toggle_en) tog <= ~tog;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Capture handshaken beats, count seq_err pulses, and verify stalled beats hold still.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_data", m_axis_tdata, snap.data);
        check("stall_ctrl", 256'({m_axis_tvalid, m_axis_tlast, m_axis_tstrb, m_axis_tuser}),
              256'({1'b1, snap.last, snap.strb, snap.user}));
      end
      if (m_axis_tvalid && m_axis_tready)
        got_q.push_back('{data: m_axis_tdata, strb: m_axis_tstrb, user: m_axis_tuser, last: m_axis_tlast});
      stall_prev = m_axis_tvalid && !m_axis_tready;
      if (stall_prev)
        snap = '{data: m_axis_tdata, strb: m_axis_tstrb, user: m_axis_tuser, last: m_axis_tlast};
      if (seq_err) seq_err_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  function automatic logic [191:0] pay(input int k);
    logic [191:0] p;
    for (int j = 0; j < 6; j++) p[32*j +: 32] = 32'(k * 256 + j);
    return p;
  endfunction

  function automatic logic [201:0] mk(input logic [191:0] p, input logic [4:0] l,
                                      input logic [2:0] t, input logic last);
    return {p, l, t, last, 1'b0};
  endfunction

  task automatic send(input logic [201:0] w);
    int n = 0;
    din = w;
    din_valid = 1'b1;
    @(negedge clk);
    while (!din_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!din_ready) check("send_timeout", 256'(din_ready), 256'(1));
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic send_pkt(input int k0, input int nw, input logic [4:0] l, input logic [127:0] tu);
    send(mk(192'(tu), 5'd0, 3'd0, 1'b0));
    for (int w = 0; w < nw; w++)
      send(mk(pay(k0 + w), (w == nw - 1) ? l : 5'd0, 3'((w % 4) + 1), w == nw - 1));
  endtask

  task automatic expect_pkt(input int k0, input int nw, input logic [127:0] tu, input logic [31:0] last_strb);
    int nl = nw * 6;
    int nb = (nl + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      beat_t e;
      e.data = '0;
      for (int i = 0; i < 8; i++) begin
        int idx = b * 8 + i;
        if (idx < nl) e.data[32*i +: 32] = 32'((k0 + idx / 6) * 256 + idx % 6);
      end
      e.strb = (b == nb - 1) ? last_strb : 32'hFFFFFFFF;
      e.last = (b == nb - 1);
      e.user = tu;
      exp_q.push_back(e);
    end
  endtask

  task automatic compare_all(input string name);
    int n = exp_q.size();
    int k = 0;
    while (got_q.size() < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    check({name, "_beats"}, 256'(got_q.size()), 256'(n));
    for (int b = 0; exp_q.size() > 0 && got_q.size() > 0; b++) begin
      beat_t g = got_q.pop_front();
      beat_t e = exp_q.pop_front();
      $display("%s beat %0d: tdata=%h tstrb=%h tlast=%0b", name, b, g.data, g.strb, g.last);
      check($sformatf("%s_data%0d", name, b), g.data, e.data);
      check($sformatf("%s_strb%0d", name, b), 256'(g.strb), 256'(e.strb));
      check($sformatf("%s_user%0d", name, b), 256'(g.user), 256'(e.user));
      check($sformatf("%s_last%0d", name, b), 256'(g.last), 256'(e.last));
    end
    exp_q.delete();
    got_q.delete();
    check({name, "_pkt_count"}, 256'(pkt_count), 256'(exp_pkts));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c0;
    @(negedge clk);
    check("rst_din_ready", 256'(din_ready), 256'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", 256'(m_axis_tvalid), 256'(0));
    check("rst_tdata", m_axis_tdata, 256'(0));
    check("rst_pkt_count", 256'(pkt_count), 256'(0));
    check("rst_seq_err", 256'(seq_err), 256'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Four data words, full final beat.
    send_pkt(1, 4, 5'd31, TU_AF);
    expect_pkt(1, 4, TU_AF, 32'hFFFFFFFF);
    exp_pkts = 1;
    compare_all("t1_full");

    // Type-2 tlast: two beats, din_ready low throughout FLUSH.
    send_pkt(2, 2, 5'd15, TU_AF);
    @(negedge clk);
    check("flush_ready0", 256'(din_ready), 256'(0));
    @(negedge clk);
    check("flush_ready1", 256'(din_ready), 256'(0));
    expect_pkt(2, 2, TU_AF, 32'h0000FFFF);
    exp_pkts = 2;
    compare_all("t2_flush");

    // Same shape under toggling tready.
    toggle_en = 1'b1;
    send_pkt(4, 2, 5'd15, TU_AF);
    expect_pkt(4, 2, TU_AF, 32'h0000FFFF);
    exp_pkts = 3;
    compare_all("t3_toggle");
    toggle_en = 1'b0;

    // Framing error: header then T=3; drop through tlast, then a clean one-word packet.
    seq_err_cnt = 0;
    send(mk(192'(TU_AF), 5'd0, 3'd0, 1'b0));
    send(mk(pay(9), 5'd0, 3'd3, 1'b0));
    send(mk(pay(10), 5'd0, 3'd1, 1'b0));
    send(mk(pay(11), 5'd7, 3'd2, 1'b1));
    send_pkt(12, 1, 5'd23, TU_EA);
    expect_pkt(12, 1, TU_EA, 32'h00FFFFFF);
    exp_pkts = 4;
    compare_all("t4_drop");
    check("t4_seq_err_pulses", 256'(seq_err_cnt), 256'(1));

    // Back-to-back packets at one word per cycle.
    c0 = cycle;
    send_pkt(20, 4, 5'd31, TU_AF);
    send_pkt(30, 4, 5'd31, TU_EA);
    check("t5_throughput", 256'(cycle - c0), 256'(10));
    expect_pkt(20, 4, TU_AF, 32'hFFFFFFFF);
    expect_pkt(30, 4, TU_EA, 32'hFFFFFFFF);
    exp_pkts = 6;
    compare_all("t5_b2b");

    // Reset mid-packet with a completed beat stalled in the output register.
    send(mk(192'(TU_EA), 5'd0, 3'd0, 1'b0));
    send(mk(pay(40), 5'd0, 3'd1, 1'b0));
    tready_lvl = 1'b0;
    send(mk(pay(41), 5'd0, 3'd2, 1'b0));
    reset = 1'b1;
    @(negedge clk);
    check("t6_rst_ready", 256'(din_ready), 256'(0));
    @(posedge clk);
    #1;
    check("t6_rst_tvalid", 256'(m_axis_tvalid), 256'(0));
    check("t6_rst_tdata", m_axis_tdata, 256'(0));
    check("t6_rst_ctrl", 256'({m_axis_tstrb, m_axis_tuser, m_axis_tlast}), 256'(0));
    check("t6_rst_pkt_count", 256'(pkt_count), 256'(0));
    reset = 1'b0;
    tready_lvl = 1'b1;
    @(posedge clk);
    #1;
    check("t6_no_partial", 256'(got_q.size()), 256'(0));
    send_pkt(50, 4, 5'd31, TU_AF);
    expect_pkt(50, 4, TU_AF, 32'hFFFFFFFF);
    exp_pkts = 1;
    compare_all("t6_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
